// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand/result handshake bundle for the nibble-serial add/subtract sequencer.
// The master side feeds operands and drains results; the slave side is the controller.
interface nibble_serial_add_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, op, a, b, cin, out_ready,
        input  in_ready, out_valid, result, cout, overflow
    );

    modport slave (
        input  in_valid, op, a, b, cin, out_ready,
        output in_ready, out_valid, result, cout, overflow
    );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add/subtract sequenced through one external 4-bit adder slice,
// least-significant nibble first, one operation in flight.
//
// state | meaning
// IDLE  | waiting for an operand set, slice inputs held at zero
// RUN   | one nibble per cycle through the slice, carry kept locally
// DONE  | result/cout/overflow held until downstream accepts
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    nibble_serial_add_ctrl_if.slave  bus,
    output logic                     busy,
    output logic [3:0]               add_a,
    output logic [3:0]               add_b,
    output logic                     add_cin,
    input  logic [3:0]               add_sum,
    input  logic                     add_cout
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = $clog2(NIB);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic [IDX_W-1:0] idx_q,      idx_d;
    logic             carry_q,    carry_d;
    logic [WIDTH-1:0] a_r_q,      a_r_d;
    logic [WIDTH-1:0] b_r_q,      b_r_d;
    logic [WIDTH-1:0] result_q,   result_d;
    logic             cout_q,     cout_d;
    logic             overflow_q, overflow_d;

    logic [3:0] a_nib;
    logic [3:0] b_nib;

    assign a_nib = a_r_q[{idx_q, 2'b00} +: 4];
    assign b_nib = b_r_q[{idx_q, 2'b00} +: 4];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            a_r_q      <= '0;
            b_r_q      <= '0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            a_r_q      <= a_r_d;
            b_r_q      <= b_r_d;
            result_q   <= result_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        a_r_d      = a_r_q;
        b_r_d      = b_r_q;
        result_d   = result_q;
        cout_d     = cout_q;
        overflow_d = overflow_q;
        add_a      = 4'h0;
        add_b      = 4'h0;
        add_cin    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Subtract is folded into an add: b is stored inverted and carry seeded with 1.
                if (bus.in_valid) begin
                    a_r_d   = bus.a;
                    b_r_d   = bus.op ? ~bus.b : bus.b;
                    carry_d = bus.op ? 1'b1 : bus.cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                add_a   = a_nib;
                add_b   = b_nib;
                add_cin = carry_q;
                result_d[{idx_q, 2'b00} +: 4] = add_sum;
                carry_d = add_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    cout_d     = add_cout;
                    overflow_d = (a_r_q[WIDTH-1] == b_r_q[WIDTH-1]) &
                                 (add_sum[3] != a_r_q[WIDTH-1]);
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE) & rst_n;
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = overflow_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl: 16-bit and 8-bit instances,
// each driving a behavioural 4-bit adder slice, results checked via scoreboards.
module tb_nibble_serial_add_ctrl;
    logic clk;
    logic rst_n;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] res;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];
    exp_t last16;

    nibble_serial_add_ctrl_if #(.WIDTH(16)) bus16 ();
    nibble_serial_add_ctrl_if #(.WIDTH(8))  bus8 ();

    logic       busy16, add_cin16, add_cout16;
    logic [3:0] add_a16, add_b16, add_sum16;
    logic       busy8, add_cin8, add_cout8;
    logic [3:0] add_a8, add_b8, add_sum8;

    assign {add_cout16, add_sum16} = 5'(add_a16) + 5'(add_b16) + 5'(add_cin16);
    assign {add_cout8,  add_sum8}  = 5'(add_a8)  + 5'(add_b8)  + 5'(add_cin8);

    nibble_serial_add_ctrl #(.WIDTH(16)) u_dut16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus16),
        .busy     (busy16),
        .add_a    (add_a16),
        .add_b    (add_b16),
        .add_cin  (add_cin16),
        .add_sum  (add_sum16),
        .add_cout (add_cout16)
    );

    nibble_serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus8),
        .busy     (busy8),
        .add_a    (add_a8),
        .add_b    (add_b8),
        .add_cin  (add_cin8),
        .add_sum  (add_sum8),
        .add_cout (add_cout8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic op, input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input int w);
        exp_t        r;
        logic [16:0] s;
        logic [15:0] m;
        logic [15:0] bb;
        logic        sa, sb, sr;
        m  = (w == 16) ? 16'hFFFF : 16'h00FF;
        bb = op ? (~b & m) : (b & m);
        s  = {1'b0, a & m} + {1'b0, bb} + {16'd0, (op ? 1'b1 : cin)};
        r.res  = s[15:0] & m;
        r.cout = s[w];
        sa = a[w-1];
        sb = b[w-1];
        sr = s[w-1];
        r.ovf = op ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        return r;
    endfunction

    task automatic issue16(input logic op, input logic [15:0] a, input logic [15:0] b,
                           input logic cin);
        vectors++;
        if (bus16.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL in_ready16_before_issue: got %b want 1", bus16.in_ready);
        end
        bus16.in_valid = 1'b1;
        bus16.op       = op;
        bus16.a        = a;
        bus16.b        = b;
        bus16.cin      = cin;
        q16.push_back(model(op, a, b, cin, 16));
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        bus16.a        = 16'hDEAD;
        bus16.b        = 16'hBEEF;
        bus16.op       = ~op;
        bus16.cin      = ~cin;
        vectors++;
        if (busy16 !== 1'b1 || bus16.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL accept16: busy=%b in_ready=%b want busy=1 in_ready=0",
                     busy16, bus16.in_ready);
        end
    endtask

    task automatic wait_done16(output int lat, output logic [15:0] seq);
        exp_t e;
        lat = 0;
        seq = '0;
        while (bus16.out_valid !== 1'b1 && lat < 40) begin
            if (lat < 4) seq[4*lat +: 4] = add_a16;
            @(posedge clk); #1;
            lat++;
        end
        vectors++;
        if (bus16.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL out_valid16_timeout: got %b after %0d edges want 1",
                     bus16.out_valid, lat);
        end
        vectors++;
        if (lat != 4) begin
            miscompares++;
            $display("FAIL latency16: got %0d edges want 4", lat);
        end
        if (q16.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard16_empty: got result %h with nothing expected",
                     bus16.result);
        end else begin
            e = q16.pop_front();
            last16 = e;
            vectors++;
            if (bus16.result !== e.res) begin
                miscompares++;
                $display("FAIL result16: got %h want %h", bus16.result, e.res);
            end
            vectors++;
            if (bus16.cout !== e.cout) begin
                miscompares++;
                $display("FAIL cout16: got %b want %b", bus16.cout, e.cout);
            end
            vectors++;
            if (bus16.overflow !== e.ovf) begin
                miscompares++;
                $display("FAIL overflow16: got %b want %b", bus16.overflow, e.ovf);
            end
        end
    endtask

    task automatic release16();
        bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        bus16.out_ready = 1'b0;
        vectors++;
        if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL release16: out_valid=%b in_ready=%b want 0/1",
                     bus16.out_valid, bus16.in_ready);
        end
        vectors++;
        if (add_a16 !== 4'h0 || add_b16 !== 4'h0 || add_cin16 !== 1'b0) begin
            miscompares++;
            $display("FAIL slice_quiet16: add_a=%h add_b=%h add_cin=%b want 0",
                     add_a16, add_b16, add_cin16);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (busy16 !== 1'b0 || bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl16: busy=%b out_valid=%b in_ready=%b want 0/0/0",
                     busy16, bus16.out_valid, bus16.in_ready);
        end
        vectors++;
        if (bus16.result !== 16'h0 || bus16.cout !== 1'b0 || bus16.overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_data16: result=%h cout=%b ovf=%b want 0",
                     bus16.result, bus16.cout, bus16.overflow);
        end
        vectors++;
        if (add_a16 !== 4'h0 || add_b16 !== 4'h0 || add_cin16 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_slice16: add_a=%h add_b=%h add_cin=%b want 0",
                     add_a16, add_b16, add_cin16);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (bus16.in_ready !== 1'b1 || bus8.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: in_ready16=%b in_ready8=%b want 1/1",
                     bus16.in_ready, bus8.in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add_basic();
        int          lat;
        logic [15:0] seq;
        issue16(1'b0, 16'h1234, 16'h0FFF, 1'b0);
        wait_done16(lat, seq);
        vectors++;
        if (seq !== 16'h1234) begin
            miscompares++;
            $display("FAIL add_a_sequence: got nibbles %h want 1234 (4,3,2,1 in issue order)", seq);
        end
        release16();
    endtask

    task automatic test_add_edges();
        int          lat;
        logic [15:0] seq;
        issue16(1'b0, 16'hFFFF, 16'h0001, 1'b0);
        wait_done16(lat, seq);
        release16();
        issue16(1'b0, 16'h7FFF, 16'h0000, 1'b1);
        wait_done16(lat, seq);
        release16();
    endtask

    task automatic test_sub();
        int          lat;
        logic [15:0] seq;
        issue16(1'b1, 16'h0005, 16'h0007, 1'b0);
        vectors++;
        if (add_a16 !== 4'h5 || add_b16 !== 4'h8 || add_cin16 !== 1'b1) begin
            miscompares++;
            $display("FAIL sub_first_nibble: add_a=%h add_b=%h add_cin=%b want 5/8/1",
                     add_a16, add_b16, add_cin16);
        end
        wait_done16(lat, seq);
        release16();
        issue16(1'b1, 16'h8000, 16'h0001, 1'b0);
        wait_done16(lat, seq);
        release16();
    endtask

    task automatic test_backpressure();
        int          lat;
        logic [15:0] seq;
        int          bad;
        issue16(1'b0, 16'h00FF, 16'h0101, 1'b1);
        wait_done16(lat, seq);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            bus16.in_valid = 1'b1;
            bus16.op       = 1'b1;
            bus16.a        = 16'(i * 16'h1111);
            bus16.b        = 16'h0F0F;
            @(posedge clk); #1;
            if (bus16.out_valid !== 1'b1 || bus16.in_ready !== 1'b0 ||
                bus16.result !== last16.res || bus16.cout !== last16.cout ||
                bus16.overflow !== last16.ovf) begin
                bad++;
                $display("FAIL backpressure_hold cycle %0d: ov=%b ir=%b res=%h want 1/0/%h",
                         i, bus16.out_valid, bus16.in_ready, bus16.result, last16.res);
            end
        end
        vectors++;
        if (bad != 0) miscompares++;
        bus16.in_valid = 1'b0;
        release16();
        issue16(1'b0, 16'h4000, 16'h4000, 1'b0);
        wait_done16(lat, seq);
        release16();
        vectors++;
        if (q16.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard16_leftover: got %0d pending want 0", q16.size());
        end
    endtask

    task automatic test_reset_mid_run();
        int          lat;
        logic [15:0] seq;
        int          seen;
        bus16.in_valid = 1'b1;
        bus16.op       = 1'b0;
        bus16.a        = 16'h1111;
        bus16.b        = 16'h2222;
        bus16.cin      = 1'b0;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (busy16 !== 1'b1 || add_a16 !== 4'h1) begin
            miscompares++;
            $display("FAIL second_run_cycle: busy=%b add_a=%h want 1/1", busy16, add_a16);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (busy16 !== 1'b0 || add_a16 !== 4'h0 || add_b16 !== 4'h0 || add_cin16 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_run: busy=%b add_a=%h add_b=%h add_cin=%b want 0",
                     busy16, add_a16, add_b16, add_cin16);
        end
        vectors++;
        if (bus16.result !== 16'h0 || bus16.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_run_state: result=%h in_ready=%b want 0/0",
                     bus16.result, bus16.in_ready);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) rst_n = 1'b1;
            @(posedge clk); #1;
            if (bus16.out_valid === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL abandoned_op_out_valid: got %0d cycles want 0", seen);
        end
        issue16(1'b0, 16'hA5A5, 16'h5A5B, 1'b1);
        wait_done16(lat, seq);
        release16();
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [15:0] seq;
        for (int i = 0; i < 8; i++) begin
            issue16(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                    1'($urandom_range(0, 1)));
            wait_done16(lat, seq);
            release16();
        end
    endtask

    task automatic test_width8();
        exp_t e;
        int   lat;
        bus8.in_valid = 1'b1;
        bus8.op       = 1'b0;
        bus8.a        = 8'hF0;
        bus8.b        = 8'h10;
        bus8.cin      = 1'b0;
        q8.push_back(model(1'b0, 16'h00F0, 16'h0010, 1'b0, 8));
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        lat = 0;
        while (bus8.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        vectors++;
        if (lat != 2 || bus8.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL latency8: got %0d edges out_valid=%b want 2 and 1", lat, bus8.out_valid);
        end
        e = q8.pop_front();
        vectors++;
        if (bus8.result !== e.res[7:0] || bus8.cout !== e.cout || bus8.overflow !== e.ovf) begin
            miscompares++;
            $display("FAIL result8: got %h/%b/%b want %h/%b/%b", bus8.result, bus8.cout,
                     bus8.overflow, e.res[7:0], e.cout, e.ovf);
        end
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
        vectors++;
        if (bus8.out_valid !== 1'b0 || busy8 !== 1'b0) begin
            miscompares++;
            $display("FAIL release8: out_valid=%b busy=%b want 0/0", bus8.out_valid, busy8);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        bus16.in_valid  = 1'b0;
        bus16.op        = 1'b0;
        bus16.a         = '0;
        bus16.b         = '0;
        bus16.cin       = 1'b0;
        bus16.out_ready = 1'b0;
        bus8.in_valid   = 1'b0;
        bus8.op         = 1'b0;
        bus8.a          = '0;
        bus8.b          = '0;
        bus8.cin        = 1'b0;
        bus8.out_ready  = 1'b0;

        test_reset();
        test_add_basic();
        test_add_edges();
        test_sub();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_width8();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
